// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch controller and the immediate generator.
// Holds the base-ISA opcode encodings both blocks decode, the fetch FSM
// state type, the trap cause codes and the reset value of the instruction
// register. No ports.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_FETCH_REQ = 2'd0,
    ST_WAIT_RSP  = 2'd1,
    ST_EXEC      = 2'd2,
    ST_HALT      = 2'd3
  } fetch_state_t;

  typedef logic [1:0] trap_cause_t;
  localparam trap_cause_t TRAP_NONE       = 2'b00;
  localparam trap_cause_t TRAP_MISALIGNED = 2'b01;
  localparam trap_cause_t TRAP_TIMEOUT    = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_sel.sv
// Next program-counter selection for the instruction held in the
// instruction register.
// Ports:
//   opcode     in  7   instr[6:0]
//   pc         in  32  address of the current instruction
//   imm        in  32  sign-extended immediate of the current instruction
//   rs1_data   in  32  JALR base register value
//   br_taken   in  1   branch comparator result
//   next_pc    out 32  selected target (32-bit modulo arithmetic)
//   misaligned out 1   target is not word-aligned (bit 1 set)
module next_pc_sel
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        br_taken,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = pc + 32'd4;
    case (opcode)
      OPC_BRANCH: if (br_taken) next_pc = pc + imm;
      OPC_JAL:    next_pc = pc + imm;
      // JALR drops bit 0 of the sum, so only bit 1 can make it misaligned.
      OPC_JALR:   next_pc = (rs1_data + imm) & ~32'h1;
      default:    ;
    endcase
  end

  // Bit 0 is not checked: only a halfword-offset target is a fetch trap.
  assign misaligned = next_pc[1];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch and PC update sequencer. Fetches one word per
// instruction, holds it in the instruction register while decode and
// execute act on it, then retires it (commit) and moves the PC, or
// halts with a sticky trap on a misaligned target or fetch timeout.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   imem_req/addr        fetch request and address (addr == pc)
//   imem_gnt             request accepted
//   imem_rvalid/rdata    returned instruction word
//   instr                instruction register
//   imm, rs1_data        immediate and JALR base for instr
//   br_taken             branch outcome for instr
//   stall                execute busy, holds EXEC
//   pc, pc_plus4         current PC and link value
//   commit               one-cycle retire strobe
//   trap, trap_cause     sticky trap flag and its cause
//
// state        | meaning
// ST_FETCH_REQ | request at pc, waiting for grant
// ST_WAIT_RSP  | granted, waiting for read data (timed)
// ST_EXEC      | instr stable; retire when stall drops
// ST_HALT      | trapped; frozen until reset
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        br_taken,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        commit,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  wait_cnt_q, wait_cnt_d;
  logic         trap_q, trap_d;
  trap_cause_t  cause_q, cause_d;
  // Keeps the request low until the first clock after reset release.
  logic         run_q;

  logic [31:0]  next_pc;
  logic         misaligned;

  next_pc_sel u_next_pc_sel (
    .opcode     (instr_q[6:0]),
    .pc         (pc_q),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .br_taken   (br_taken),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= TRAP_NONE;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      run_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    commit     = 1'b0;

    case (state_q)
      ST_FETCH_REQ: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            wait_cnt_d = '0;
            if (imem_rvalid) begin
              instr_d = imem_rdata;
              state_d = ST_EXEC;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end
        end
      end

      ST_WAIT_RSP: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        // rvalid is tested first so data on the limit cycle still wins.
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else if ((WAIT_LIMIT != 0) && (wait_cnt_d == WAIT_LIMIT)) begin
          state_d = ST_HALT;
          trap_d  = 1'b1;
          cause_d = TRAP_TIMEOUT;
        end
      end

      ST_EXEC: begin
        if (!stall) begin
          if (misaligned) begin
            state_d = ST_HALT;
            trap_d  = 1'b1;
            cause_d = TRAP_MISALIGNED;
          end else begin
            commit  = 1'b1;
            pc_d    = next_pc;
            state_d = ST_FETCH_REQ;
          end
        end
      end

      ST_HALT: ;

      default: state_d = ST_HALT;
    endcase
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign instr      = instr_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized instructions, checked against a PC/trap reference model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        br_taken;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        commit;
  logic        trap;
  logic [1:0]  trap_cause;

  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] exp_pc;
  logic        halted;

  localparam logic [31:0] W_NOP  = 32'h0000_0013;
  localparam logic [31:0] W_BEQ  = 32'h0000_0063;
  localparam logic [31:0] W_JAL  = 32'h0000_006F;
  localparam logic [31:0] W_JALR = 32'h0000_0067;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .br_taken    (br_taken),
    .stall       (stall),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .commit      (commit),
    .trap        (trap),
    .trap_cause  (trap_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {misaligned, target} from the architectural rules.
  function automatic logic [32:0] ref_next(input logic [31:0] word, pc_v, imm_v, rs1_v,
                                           input logic br);
    logic [31:0] t;
    case (word[6:0])
      7'h63:   t = br ? pc_v + imm_v : pc_v + 32'd4;
      7'h6F:   t = pc_v + imm_v;
      7'h67:   t = ((rs1_v + imm_v) >> 1) << 1;
      default: t = pc_v + 32'd4;
    endcase
    return {((t % 4) >= 2), t};
  endfunction

  // Asserted between clock edges, so the first checks prove the reset is async.
  task automatic apply_reset();
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    stall = 1'b0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, W_NOP);
    check("rst_trap", trap, 0);
    check("rst_cause", trap_cause, 0);
    check("rst_commit", commit, 0);
    step();
    step();
    rst = 1'b0;
    exp_pc = 32'h0;
    halted = 1'b0;
    #1;
    check("rel_req", imem_req, 0);
    step();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
  endtask

  task automatic run_instr(input logic [31:0] word, imm_v, rs1_v, input logic br,
                           input int gnt_dly, input int rv_dly, input int stall_n);
    logic [32:0] r;
    imm = imm_v;
    rs1_data = rs1_v;
    br_taken = br;
    stall = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      #1;
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, exp_pc);
      check("fetch_commit", commit, 0);
      step();
    end
    imem_gnt = 1'b1;
    imem_rvalid = (rv_dly == 0);
    imem_rdata = (rv_dly == 0) ? word : $urandom;
    #1;
    check("gnt_req", imem_req, 1);
    check("gnt_addr", imem_addr, exp_pc);
    step();
    imem_gnt = 1'b0;
    for (int k = 1; k <= rv_dly; k++) begin
      imem_rvalid = (k == rv_dly);
      imem_rdata = (k == rv_dly) ? word : $urandom;
      #1;
      check("wait_req", imem_req, 0);
      check("wait_trap", trap, 0);
      step();
    end
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    r = ref_next(word, exp_pc, imm_v, rs1_v, br);
    for (int s = 0; s < stall_n; s++) begin
      stall = 1'b1;
      imem_rvalid = 1'($urandom_range(0, 1));
      #1;
      check("stall_instr", instr, word);
      check("stall_commit", commit, 0);
      check("stall_pc", pc, exp_pc);
      step();
    end
    stall = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("exec_instr", instr, word);
    check("exec_pc4", pc_plus4, exp_pc + 32'd4);
    check("exec_commit", commit, {31'b0, ~r[32]});
    step();
    if (r[32]) begin
      halted = 1'b1;
      check("mis_trap", trap, 1);
      check("mis_cause", trap_cause, 2'b01);
      check("mis_pc", pc, exp_pc);
      check("mis_req", imem_req, 0);
    end else begin
      exp_pc = r[31:0];
      check("next_pc", pc, exp_pc);
      check("next_addr", imem_addr, exp_pc);
      check("next_req", imem_req, 1);
      check("next_trap", trap, 0);
    end
  endtask

  task automatic check_frozen(input logic [31:0] exp_instr, input logic [1:0] cause);
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata = $urandom;
      stall = 1'b0;
      #1;
      check("halt_req", imem_req, 0);
      check("halt_commit", commit, 0);
      check("halt_pc", pc, exp_pc);
      check("halt_instr", instr, exp_instr);
      check("halt_trap", trap, 1);
      check("halt_cause", trap_cause, cause);
      step();
    end
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    logic [31:0] iv;
    logic [6:0]  opc;
    imm = '0;
    rs1_data = '0;
    br_taken = 1'b0;
    imem_rdata = '0;
    apply_reset();

    // Sequential NOPs, fastest handshake: pc 0,4,8,C.
    for (int n = 0; n < 4; n++) run_instr(W_NOP, 32'h0, 32'h0, 1'b0, 0, 0, 0);

    // Jump to 0x100, then branches taken and not taken.
    run_instr(W_JAL, 32'h0000_00F0, 32'h0, 1'b0, 0, 0, 0);
    run_instr(W_BEQ, 32'hFFFF_FFF0, 32'h0, 1'b1, 0, 0, 0);
    check("beq_taken", exp_pc, 32'h0000_00F0);
    run_instr(W_JAL, 32'h0000_0010, 32'h0, 1'b0, 0, 0, 0);
    run_instr(W_BEQ, 32'hFFFF_FFF0, 32'h0, 1'b0, 0, 0, 0);
    check("beq_not_taken", pc, 32'h0000_0104);

    // JALR clears bit 0; JAL to a halfword target traps.
    run_instr(W_JALR, 32'h0000_0004, 32'h0000_2001, 1'b0, 1, 2, 1);
    check("jalr_pc", pc, 32'h0000_2004);
    run_instr(W_JAL, 32'h0000_0006, 32'h0, 1'b0, 0, 0, 0);
    check("jal_mis_halted", halted, 1);
    check_frozen(W_JAL, 2'b01);
    apply_reset();

    // Slow handshake and long stall; then data exactly on the limit cycle.
    run_instr(W_NOP, 32'h0, 32'h0, 1'b0, 3, 5, 4);
    run_instr(W_NOP, 32'h0, 32'h0, 1'b0, 0, 16, 0);
    check("limit_rvalid_pc", pc, 32'h0000_0008);

    // Timeout: no read data for 16 WAIT_RSP cycles.
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    step();
    imem_gnt = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      check("to_no_trap_yet", trap, 0);
      step();
    end
    check("to_trap", trap, 1);
    check("to_cause", trap_cause, 2'b10);
    check_frozen(W_NOP, 2'b10);
    apply_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: opc = 7'h63;
        1: opc = 7'h6F;
        2: opc = 7'h67;
        3: opc = 7'h13;
        4: opc = 7'h03;
        default: begin r = $urandom; opc = r[6:0]; end
      endcase
      r = $urandom;
      w = {r[31:7], opc};
      iv = $urandom;
      iv = ($urandom_range(0, 7) == 0) ? (iv | 32'h2) & ~32'h1 : iv & ~32'h3;
      run_instr(w, iv, $urandom & ~32'h2, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3));
      if (halted) begin
        check_frozen(w, 2'b01);
        apply_reset();
      end
    end

    // Reset while waiting for read data restarts fetch at RESET_PC.
    run_instr(W_JAL, 32'h0000_0040, 32'h0, 1'b0, 0, 0, 0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    step();
    step();
    apply_reset();
    run_instr(W_NOP, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    check("restart_pc", pc, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequences instruction fetch and program-counter update around the immediate generator and execute datapath. Per instruction, the FSM issues an instruction-memory request, latches the returned word into an instruction register, and holds it while the decoder and immediate generator act on it. It then computes the next PC (sequential, branch, JAL or JALR) from the externally generated immediate. It also produces the commit strobe that gates architectural writes and traps on a misaligned fetch target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
WAIT_LIMIT, 16, maximum cycles in WAIT_RSP before a bus-timeout trap; 0 disables the timeout.

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (equals pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  fetched instruction word
instr  out  32  instruction register, to decoder and immediate generator
imm  in  32  sign-extended immediate for instr (combinational from immediate generator)
rs1_data  in  32  register-file rs1 read value (JALR base)
br_taken  in  1  branch comparator result for the current branch
stall  in  1  execute not finished (e.g. data memory busy); holds EXEC
pc  out  32  current instruction address
pc_plus4  out  32  pc + 4 (JAL/JALR link value)
commit  out  1  one-cycle pulse; instruction retires, writes enabled
trap  out  1  sticky; set on misaligned target or timeout
trap_cause  out  2  00 none, 01 misaligned target, 10 fetch timeout

Behaviour:
- Reset (async, any state): pc=RESET_PC, instr=32'h0000_0013 (NOP), imem_req=0, commit=0, trap=0, trap_cause=00, wait counter=0, state=FETCH_REQ on the first clock after release.
- States: FETCH_REQ, WAIT_RSP, EXEC, HALT.
- FETCH_REQ: imem_req=1, imem_addr=pc held stable until imem_gnt. If gnt and rvalid arrive in the same cycle, latch rdata and go to EXEC. On gnt only, go to WAIT_RSP.
- WAIT_RSP: imem_req=0; counter increments each cycle. On rvalid, instr<=imem_rdata, go to EXEC. If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT without rvalid, go to HALT with trap_cause=10. rvalid in the same cycle as the limit wins (no trap).
- EXEC: instr is stable. While stall=1, remain in EXEC with no commit and no PC change. On stall=0, set commit=1 for exactly this cycle, pc<=next_pc, and go to FETCH_REQ.
  - Minimum instruction latency is 2 cycles (gnt+rvalid together, no stall).
- next_pc, selected by instr[6:0]:
  - 1100011 branch: br_taken ? pc+imm : pc+4
  - 1101111 JAL: pc+imm
  - 1100111 JALR: (rs1_data+imm) & ~32'h1
  - any other opcode: pc+4
  - All adds are 32-bit modulo; wrap-around at 2^32 is legal and untrapped.
- Misaligned target: if the selected next_pc[1] is 1 at the EXEC exit, commit is still 0 for that instruction, pc is unchanged, and the FSM goes to HALT with trap_cause=01. Bit 0 of a JALR target is cleared and never traps.
- HALT: all outputs frozen, imem_req=0, trap=1. Exits only on rst.
- imem_rvalid seen outside WAIT_RSP/FETCH_REQ is ignored.
- pc_plus4 is combinational pc+4 and valid in every state.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR (the immediate generator decodes the same encodings, so both share one definition)
  - fetch_state_t enum
  - trap_cause_t constants
  - NOP_INSTR = 32'h0000_0013
- One combinational sub-module, next_pc_sel: inputs opcode, pc, imm, rs1_data, br_taken; outputs next_pc and misaligned. Verified standalone.

Test Plan:
- Reset then sequential fetch: gnt+rvalid same cycle, rdata=32'h0000_0013, RESET_PC=0 -> commit every 2nd cycle, pc 0,4,8,C.
- Taken branch: instr at pc=0x100 = BEQ, imm=32'hFFFF_FFF0, br_taken=1 -> next fetch addr 0x0F0. Same with br_taken=0 -> 0x104.
- JALR: rs1_data=0x2001, imm=0x4 -> pc=0x2004 (bit 0 cleared), pc_plus4 during EXEC = old pc+4. JAL with imm=0x6 -> trap=1, trap_cause=01, no commit, imem_req stays 0.
- Handshake delays: gnt 3 cycles late, rvalid 5 cycles after gnt, stall high 4 cycles in EXEC -> imem_addr stable until gnt, single commit after stall drops.
- Timeout: WAIT_LIMIT=16, rvalid never arrives -> HALT after 16 WAIT_RSP cycles, trap_cause=10. Repeat with rvalid exactly at cycle 16 -> no trap.
- Async reset asserted mid-WAIT_RSP and mid-HALT -> outputs return to reset values immediately without a clock edge, then fetch restarts at RESET_PC.
